// File: rtl/traffic_display_scan_if.sv
// rtl/traffic_display_scan_if.sv - countdown/light inputs and display/lamp outputs of the scan block
interface traffic_display_scan_if;
  logic [3:0] A_Time_L;
  logic [3:0] A_Time_H;
  logic [3:0] B_Time_L;
  logic [3:0] B_Time_H;
  logic       A_Light;
  logic       B_Light;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic       LED_A_G;
  logic       LED_A_R;
  logic       LED_B_G;
  logic       LED_B_R;

  modport master (
    output A_Time_L, A_Time_H, B_Time_L, B_Time_H, A_Light, B_Light,
    input  SEG, AN, LED_A_G, LED_A_R, LED_B_G, LED_B_R
  );

  modport slave (
    input  A_Time_L, A_Time_H, B_Time_L, B_Time_H, A_Light, B_Light,
    output SEG, AN, LED_A_G, LED_A_R, LED_B_G, LED_B_R
  );
endinterface

// File: rtl/traffic_display_scan.sv
// rtl/traffic_display_scan.sv - 4-digit multiplexed 7-segment scanner with frame snapshots, blanking and blink
module traffic_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                   CLK,
  input  logic                   R,
  traffic_display_scan_if.slave  disp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [0:0] GUARD_S = 1'b0;
  localparam logic [0:0] SHOW_S  = 1'b1;

  logic [CW-1:0] slot_cnt;
  logic [1:0]    digit;
  logic [FW-1:0] frame_cnt;
  logic          blink;
  logic [3:0]    snap_ah, snap_al, snap_bh, snap_bl;
  logic          snap_a_green, snap_b_green;
  logic          led_ag, led_ar, led_bg, led_br;

  logic [0:0]    state;
  logic          slot_end, frame_start, frame_end, conflict;
  logic          blink_a, blink_b, blank;
  logic [3:0]    cur_val;
  logic [6:0]    dec_seg;

  assign state       = (slot_cnt < CW'(GUARD)) ? GUARD_S : SHOW_S;
  assign slot_end    = (slot_cnt == CW'(SCAN_DIV - 1));
  assign frame_start = (slot_cnt == '0) && (digit == 2'd3);
  assign frame_end   = slot_end && (digit == 2'd0);
  assign conflict    = (disp.A_Light == disp.B_Light);

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      slot_cnt     <= '0;
      digit        <= 2'd3;
      frame_cnt    <= '0;
      blink        <= 1'b0;
      snap_ah      <= 4'd0;
      snap_al      <= 4'd0;
      snap_bh      <= 4'd0;
      snap_bl      <= 4'd0;
      snap_a_green <= 1'b0;
      snap_b_green <= 1'b0;
      led_ag       <= 1'b0;
      led_ar       <= 1'b0;
      led_bg       <= 1'b0;
      led_br       <= 1'b0;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end)
        digit <= digit - 2'd1;
      if (frame_end) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      // Everything shown during a frame comes from this capture, so it never tears.
      if (frame_start) begin
        snap_ah      <= disp.A_Time_H;
        snap_al      <= disp.A_Time_L;
        snap_bh      <= disp.B_Time_H;
        snap_bl      <= disp.B_Time_L;
        snap_a_green <= disp.A_Light;
        snap_b_green <= disp.B_Light;
        led_ag       <= disp.A_Light | conflict;
        led_ar       <= ~disp.A_Light | conflict;
        led_bg       <= disp.B_Light | conflict;
        led_br       <= ~disp.B_Light | conflict;
      end
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  // A green road in its last 1..3 seconds flashes both of its digits.
  assign blink_a = snap_a_green && (snap_ah == 4'd0) && (snap_al != 4'd0) && (snap_al <= 4'd3);
  assign blink_b = snap_b_green && (snap_bh == 4'd0) && (snap_bl != 4'd0) && (snap_bl <= 4'd3);

  always_comb begin
    cur_val = 4'd0;
    case (digit)
      2'd3:    cur_val = snap_ah;
      2'd2:    cur_val = snap_al;
      2'd1:    cur_val = snap_bh;
      default: cur_val = snap_bl;
    endcase
  end

  assign dec_seg = seg_decode(cur_val);
  assign blank   = (digit[0] && (cur_val == 4'd0)) ||
                   (blink && (digit[1] ? blink_a : blink_b));

  assign disp.AN      = (state == GUARD_S) ? 4'hF : ~(4'b0001 << digit);
  assign disp.SEG     = ((state == GUARD_S) || blank) ? 7'h7F : dec_seg;
  assign disp.LED_A_G = led_ag;
  assign disp.LED_A_R = led_ar;
  assign disp.LED_B_G = led_bg;
  assign disp.LED_B_R = led_br;

endmodule

// File: tb/tb_traffic_display_scan.sv
// tb/tb_traffic_display_scan.sv - scoreboard bench for traffic_display_scan (SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2)
module tb_traffic_display_scan;

  logic CLK = 1'b0;
  logic R   = 1'b0;
  always #5 CLK = ~CLK;

  traffic_display_scan_if dif ();

  traffic_display_scan #(.SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2)) dut (
    .CLK  (CLK),
    .R    (R),
    .disp (dif)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] led;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         fails    = 0;
  int         frame_no = 0;
  logic [3:0] last_led = 4'b0000;

  function automatic logic [3:0] leds();
    return {dif.LED_A_G, dif.LED_A_R, dif.LED_B_G, dif.LED_B_R};
  endfunction

  // Blink phase is 1 in frames 2,3, 6,7, ... counted from reset release.
  function automatic bit phase_of(input int f);
    return ((f / 2) % 2) == 1;
  endfunction

  task automatic set_inputs(input logic [3:0] ah, al, bh, bl, input logic agr, bgr);
    dif.A_Time_H = ah;
    dif.A_Time_L = al;
    dif.B_Time_H = bh;
    dif.B_Time_L = bl;
    dif.A_Light  = agr;
    dif.B_Light  = bgr;
  endtask

  task automatic push_frame(input logic [6:0] s3, s2, s1, s0, input logic [3:0] led);
    logic [6:0] segs [4];
    logic [3:0] ans  [4];
    segs[0] = s3; segs[1] = s2; segs[2] = s1; segs[3] = s0;
    ans[0]  = 4'b0111; ans[1] = 4'b1011; ans[2] = 4'b1101; ans[3] = 4'b1110;
    for (int s = 0; s < 4; s++) begin
      sb.push_back('{an: 4'hF, seg: 7'h7F, led: (s == 0) ? last_led : led});
      for (int p = 0; p < 3; p++)
        sb.push_back('{an: ans[s], seg: segs[s], led: led});
    end
    last_led = led;
    frame_no++;
  endtask

  task automatic drain_scoreboard(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL %s scoreboard empty at cycle %0d", tag, i);
      end else begin
        e = sb.pop_front();
        if (dif.AN !== e.an) begin
          fails++;
          $display("FAIL %s AN cycle %0d: got %b expected %b", tag, i, dif.AN, e.an);
        end
        checks++;
        if (dif.SEG !== e.seg) begin
          fails++;
          $display("FAIL %s SEG cycle %0d: got %h expected %h", tag, i, dif.SEG, e.seg);
        end
        checks++;
        if (leds() !== e.led) begin
          fails++;
          $display("FAIL %s LED cycle %0d: got %b expected %b", tag, i, leds(), e.led);
        end
      end
    end
  endtask

  task automatic test_reset();
    set_inputs(4'd2, 4'd5, 4'd0, 4'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (dif.AN !== 4'hF || dif.SEG !== 7'h7F || leds() !== 4'b0000) begin
        fails++;
        $display("FAIL reset_hold: AN=%b SEG=%h LED=%b expected AN=1111 SEG=7f LED=0000", dif.AN, dif.SEG, leds());
      end
    end
    @(posedge CLK); #1 R = 1'b1;
    repeat (7) @(negedge CLK);
    R = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dif.AN !== 4'hF || dif.SEG !== 7'h7F || leds() !== 4'b0000) begin
        fails++;
        $display("FAIL reset_midscan: AN=%b SEG=%h LED=%b expected AN=1111 SEG=7f LED=0000", dif.AN, dif.SEG, leds());
      end
      @(negedge CLK);
    end
    @(posedge CLK); #1 R = 1'b1;
    frame_no = 0;
    last_led = 4'b0000;
    push_frame(7'h24, 7'h12, 7'h7F, 7'h78, 4'b1001);
    drain_scoreboard(16, "first_frame");
  endtask

  task automatic test_snapshot();
    push_frame(7'h24, 7'h12, 7'h7F, 7'h78, 4'b1001);
    drain_scoreboard(14, "tear_free");
    dif.A_Time_L = 4'd4;
    drain_scoreboard(2, "tear_free_tail");
    push_frame(7'h24, 7'h19, 7'h7F, 7'h78, 4'b1001);
    drain_scoreboard(16, "next_frame");
  endtask

  task automatic test_blink();
    set_inputs(4'd0, 4'd3, 4'd0, 4'd7, 1'b1, 1'b0);
    for (int f = 0; f < 4; f++) begin
      push_frame(7'h7F, phase_of(frame_no) ? 7'h7F : 7'h30, 7'h7F, 7'h78, 4'b1001);
      drain_scoreboard(16, "blink_green");
    end
    set_inputs(4'd0, 4'd3, 4'd0, 4'd7, 1'b0, 1'b1);
    for (int f = 0; f < 2; f++) begin
      push_frame(7'h7F, 7'h30, 7'h7F, 7'h78, 4'b0110);
      drain_scoreboard(16, "no_blink_red");
    end
  endtask

  task automatic test_invalid_conflict();
    set_inputs(4'd0, 4'd3, 4'd0, 4'hC, 1'b1, 1'b1);
    for (int f = 0; f < 2; f++) begin
      push_frame(7'h7F, phase_of(frame_no) ? 7'h7F : 7'h30, 7'h7F, 7'h3F, 4'b1111);
      drain_scoreboard(16, "dash_conflict");
    end
    set_inputs(4'd2, 4'd5, 4'hF, 4'hC, 1'b1, 1'b1);
    push_frame(7'h24, 7'h12, 7'h3F, 7'h3F, 4'b1111);
    drain_scoreboard(16, "dash_tens");
  endtask

  task automatic test_digits();
    set_inputs(4'd8, 4'd9, 4'd1, 4'd6, 1'b1, 1'b0);
    push_frame(7'h00, 7'h10, 7'h79, 7'h02, 4'b1001);
    drain_scoreboard(16, "digits");
  endtask

  task automatic test_async_reset();
    push_frame(7'h00, 7'h10, 7'h79, 7'h02, 4'b1001);
    drain_scoreboard(10, "pre_reset");
    R = 1'b0;
    #1;
    checks++;
    if (dif.AN !== 4'hF || dif.SEG !== 7'h7F || leds() !== 4'b0000) begin
      fails++;
      $display("FAIL async_reset: AN=%b SEG=%h LED=%b expected AN=1111 SEG=7f LED=0000", dif.AN, dif.SEG, leds());
    end
    sb.delete();
    set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1 R = 1'b1;
    frame_no = 0;
    last_led = 4'b0000;
    push_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'b0110);
    drain_scoreboard(16, "restart");
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_blink();
    test_invalid_conflict();
    test_digits();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
